// File: rtl/wait_pkg.sv
// Shared types and constants for the wait requester.
// Holds the FSM state encoding, default count width and watchdog margin.
package wait_pkg;

  localparam int COUNTER_SIZE_DEF = 8;

  // Extra cycles allowed beyond count_to before the watchdog fires.
  localparam int WD_MARGIN = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ZERO  = 2'd3
  } state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous command FIFO for the wait requester.
// Ports: clock/reset, push/din write, pop/dout head read, full/empty.
// dout is the head word and is valid whenever empty is low.
// Pushes while full and pops while empty are ignored.
module cmd_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int PTR_SIZE = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_SIZE:0] FULL_CNT =
    (PTR_SIZE+1)'(DEPTH);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_SIZE-1:0] wptr;
  logic [PTR_SIZE-1:0] rptr;
  logic [PTR_SIZE:0]   cnt;
  logic                do_push;
  logic                do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  // Storage needs no reset: the empty flag guards every read.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wptr] <= din;
    end
  end

  // DEPTH is a power of two, so pointers wrap by overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/wait_requester.sv
// Initiator for the start/busy/count_to delay-timer handshake.
// Queues wait commands, issues each to the timer, pulses done per finish.
// Ports: clock, reset (async, high); cmd_valid/cmd_count/cmd_ready in;
// waiter_start/waiter_count_to out, waiter_busy in; done/idle/error out.
// Optional macro WAIT_WATCHDOG_EN adds a sticky busy-timeout error.
module wait_requester
  import wait_pkg::*;
#(
  parameter int COUNTER_SIZE = COUNTER_SIZE_DEF,
  parameter int DEPTH        = 4,
  parameter int PTR_SIZE     = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  input  logic [COUNTER_SIZE-1:0] cmd_count,
  output logic                    cmd_ready,
  output logic                    waiter_start,
  output logic [COUNTER_SIZE-1:0] waiter_count_to,
  input  logic                    waiter_busy,
  output logic                    done,
  output logic                    idle,
  output logic                    error
);

  state_t                  state;
  state_t                  state_n;
  logic [COUNTER_SIZE-1:0] head;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;
  logic                    done_n;
  logic                    timeout;

  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign idle      = empty && (state == IDLE);

  cmd_fifo #(
    .WIDTH   (COUNTER_SIZE),
    .DEPTH   (DEPTH),
    .PTR_SIZE(PTR_SIZE)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (cmd_count),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  always_comb begin
    state_n      = state;
    pop          = 1'b0;
    waiter_start = 1'b0;
    done_n       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          // A zero count would make the timer run a full wrap.
          if (head == '0) begin
            state_n = ZERO;
          end else begin
            state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        waiter_start = 1'b1;
        state_n      = WAIT;
      end
      WAIT: begin
        if (!waiter_busy) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (timeout) begin
          state_n = IDLE;
        end
      end
      ZERO: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // count_to only changes on a pop, so the timer sees a stable value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      done            <= 1'b0;
      waiter_count_to <= '0;
    end else begin
      state <= state_n;
      done  <= done_n;
      if (pop) begin
        waiter_count_to <= head;
      end
    end
  end

`ifdef WAIT_WATCHDOG_EN
  logic [COUNTER_SIZE+1:0] wd_cnt;
  logic [COUNTER_SIZE+1:0] wd_limit;

  // wd_cnt is 0 in the first WAIT cycle, so the limit is margin-1.
  assign wd_limit = {2'b00, waiter_count_to}
                  + (COUNTER_SIZE+2)'(WD_MARGIN - 1);
  assign timeout  = waiter_busy && (wd_cnt == wd_limit);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == WAIT) begin
      wd_cnt <= wd_cnt + 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      error <= 1'b0;
    end else if ((state == WAIT) && timeout) begin
      error <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

endmodule

// File: doc/wait_requester.md
Name: wait_requester

Overview:
- Initiator side of the start/busy/count_to delay-timer handshake. The timer it drives is the existing 8-bit delay waiter.
- Buffers wait commands from an upstream controller in a small FIFO, issues them one at a time to the timer, and waits for busy to fall.
- Reports each completion with a one-cycle done pulse.
- Sits between sequencing logic (e.g. display/LCD init steps) and the delay timer.

Parameters:
- COUNTER_SIZE, 8: width of wait counts; must match the timer's COUNTER_SIZE.
- DEPTH, 4: command FIFO entries; power of two, at least 2.
- PTR_SIZE, 2: log2(DEPTH).

Ports:
- clock  in  1: single clock; all logic rising-edge.
- reset  in  1: asynchronous, active-high; clears all state.
- cmd_valid  in  1: upstream offers a command this cycle.
- cmd_count  in  COUNTER_SIZE: requested wait length, in clock cycles.
- cmd_ready  out  1: FIFO can accept; equals !full.
- waiter_start  out  1: one-cycle start pulse to the timer.
- waiter_count_to  out  COUNTER_SIZE: count presented to the timer.
- waiter_busy  in  1: timer busy (timer's start OR running state).
- done  out  1: one-cycle pulse per completed command.
- idle  out  1: high when FIFO is empty and FSM is in IDLE.
- error  out  1: watchdog flag (see Optional Feature).

Behaviour:
- Reset values: cmd_ready=1, waiter_start=0, waiter_count_to=0, done=0, idle=1, error=0. FIFO empty, FSM in IDLE.
- FIFO push: occurs when cmd_valid && cmd_ready.
- FIFO pop: performed only by the FSM in IDLE.
- Simultaneous push and pop when not full: both happen, occupancy unchanged.
- Full: cmd_ready=0 and pushes are ignored. Data is never overwritten.
- Pointer wrap: pointers wrap modulo DEPTH. Occupancy counter is PTR_SIZE+1 bits.
- FSM states: IDLE, ISSUE, WAIT, ZERO.
- IDLE with FIFO non-empty: pop the head and register it into waiter_count_to.
  - Popped count == 0: go to ZERO. Zero would make the timer run a full wrap, so it is never issued.
  - Otherwise: go to ISSUE.
- ISSUE: waiter_start=1 for exactly this cycle, then go to WAIT.
- WAIT: waiter_start=0.
  - waiter_busy low: set done the next cycle, go to IDLE.
  - waiter_busy high: stay.
- ZERO: done pulses the next cycle, go to IDLE. No start is issued.
- waiter_count_to is held stable from the pop until the next pop. The timer re-registers count_to every cycle, so the value must not change mid-wait.
- Latency for count N>0, with the pop in cycle 0:
  - start in cycle 1;
  - busy high in cycles 1..N+1;
  - busy low observed in cycle N+2;
  - done high in cycle N+3.
- Back-to-back commands: the next pop occurs in the same cycle done is high. Minimum gap between start pulses is N+3 cycles.
- Reset mid-operation: FSM returns to IDLE, FIFO is flushed, no done is produced. The timer shares the same reset.
- waiter_busy high while in IDLE: ignored.

Optional Feature:
- Macro WAIT_WATCHDOG_EN.
- Defined:
  - A COUNTER_SIZE+2-bit cycle counter runs in WAIT.
  - If busy is still high after waiter_count_to+4 cycles in WAIT, set error (sticky until reset), emit no done, and return to IDLE.
  - Queued commands continue to be processed.
- Undefined: no counter is built, error is tied 0, and WAIT waits indefinitely.

Decomposition:
- Package wait_pkg holds:
  - state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, ZERO=2'd3);
  - default COUNTER_SIZE;
  - watchdog margin constant WD_MARGIN=4.
- Sub-module cmd_fifo (parameters: width, DEPTH, PTR_SIZE).
  - Ports: push, pop, din, dout, full, empty.
  - dout is the head word, valid whenever !empty.

Test Plan:
- Push count=3 with the real timer attached → start pulse 1 cycle after the pop, busy high 4 cycles, done exactly 6 cycles after the pop, idle returns to 1.
- Push 5, 1, 2 back-to-back → three starts with waiter_count_to 5, 1, 2; three done pulses; count_to stable throughout each wait.
- Fill with 4 pushes while a 200-cycle wait runs → cmd_ready=0 after the 4th push; 5th push ignored; then exactly 4 dones in FIFO order.
- Push count=0 → no waiter_start; done 2 cycles after the pop.
- Assert reset while in WAIT with 2 queued commands → all outputs at reset values next edge, FIFO empty, no done afterwards.
- With WAIT_WATCHDOG_EN, force waiter_busy=1 on count=2 → error=1 after 6 WAIT cycles, no done, next queued command still issued.
